// File: rtl/stream_test_driver.sv
// rtl/stream_test_driver.sv - bring-up traffic generator: startup delay, one mgmt beat, table replay, done
//
// Sequence per run: IDLE/DONE -(start)-> STARTUP -> MGMT -> GAP -> STREAM -> TAIL -> DONE.
// A start is accepted only in IDLE or DONE. The word table can be written only
// in those same two states. Table contents are not cleared by reset.
//
// Optional build macro STREAM_TEST_DRIVER_REPEAT_EN adds two ports, repeat_count
// and pass_cnt. With it, the table is replayed repeat_count+1 times. Each pass is
// framed as its own packet, and the passes follow one another with no gap.
//
// Ports:
//   clk, reset          single clock; synchronous active-high reset
//   start               one-cycle run request (ignored while busy)
//   num_words           words per pass, sampled on accepted start, clamped to DEPTH
//   mgmt_value          mgmt payload, sampled on accepted start
//   tbl_wr_en/addr/data word table write port
//   mgmt_valid/data     Avalon-ST mgmt source; mgmt_ready from sink
//   src_valid/data      Avalon-ST stream source with startofpacket/endofpacket; src_ready from sink
//   busy                high in any state other than IDLE/DONE
//   done                high in DONE until the next accepted start or reset
//   repeat_count        (macro only) extra passes, sampled on accepted start
//   pass_cnt            (macro only) completed passes in the current run

module stream_test_driver #(
    parameter int DATA_W        = 16,
    parameter int DEPTH         = 8,
    parameter int MGMT_W        = 8,
    parameter int STARTUP_DELAY = 2,
    parameter int TAIL_DELAY    = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [$clog2(DEPTH+1)-1:0]   num_words,
    input  logic [MGMT_W-1:0]            mgmt_value,
`ifdef STREAM_TEST_DRIVER_REPEAT_EN
    input  logic [7:0]                   repeat_count,
    output logic [7:0]                   pass_cnt,
`endif
    input  logic                         tbl_wr_en,
    input  logic [$clog2(DEPTH)-1:0]     tbl_wr_addr,
    input  logic [DATA_W-1:0]            tbl_wr_data,
    output logic                         mgmt_valid,
    output logic [MGMT_W-1:0]            mgmt_data,
    input  logic                         mgmt_ready,
    output logic                         src_valid,
    output logic [DATA_W-1:0]            src_data,
    output logic                         src_startofpacket,
    output logic                         src_endofpacket,
    input  logic                         src_ready,
    output logic                         busy,
    output logic                         done
);

    localparam int LEN_W   = $clog2(DEPTH + 1);
    localparam int AW      = $clog2(DEPTH);
    localparam int CNT_MAX = (STARTUP_DELAY > TAIL_DELAY) ? STARTUP_DELAY : TAIL_DELAY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STARTUP = 3'd1,
        S_MGMT    = 3'd2,
        S_GAP     = 3'd3,
        S_STREAM  = 3'd4,
        S_TAIL    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [DATA_W-1:0]  tbl [DEPTH];
    logic [CNT_W-1:0]   cnt;
    logic [AW-1:0]      idx;
    logic [LEN_W-1:0]   len_q;
    logic [MGMT_W-1:0]  mgmt_q;
    logic [LEN_W-1:0]   num_clamped;

    logic               idle_like;
    logic               start_acc;
    logic               startup_end;
    logic               tail_end;
    logic               last_beat;
    logic               last_pass;
    logic               src_fire;

`ifdef STREAM_TEST_DRIVER_REPEAT_EN
    logic [7:0]         rep_q;
`endif

    // Start and table writes are legal only when no run is in flight.
    assign idle_like   = (state == S_IDLE) || (state == S_DONE);
    assign start_acc   = start && idle_like;
    assign num_clamped = (num_words > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : num_words;

    // The same counter times both delay states. It is zero on entry to each of them.
    assign startup_end = (cnt == CNT_W'(STARTUP_DELAY - 1));
    assign tail_end    = (cnt == CNT_W'(TAIL_DELAY - 1));

    // STREAM is only entered with len_q > 0, so len_q - 1 cannot underflow here.
    assign last_beat   = (LEN_W'(idx) == (len_q - LEN_W'(1)));
    assign src_fire    = src_valid && src_ready;

`ifdef STREAM_TEST_DRIVER_REPEAT_EN
    assign last_pass   = (pass_cnt == rep_q);
`else
    assign last_pass   = 1'b1;
`endif

    // Table write port. This is not reset, so a table loaded before a reset is still
    // there afterwards.
    always_ff @(posedge clk) begin
        if (tbl_wr_en && idle_like) begin
            tbl[tbl_wr_addr] <= tbl_wr_data;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_STARTUP;
                end
            end
            S_STARTUP: begin
                if (startup_end) begin
                    state_nxt = S_MGMT;
                end
            end
            S_MGMT: begin
                if (mgmt_ready) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                state_nxt = (len_q != '0) ? S_STREAM : S_TAIL;
            end
            S_STREAM: begin
                if (src_ready && last_beat && last_pass) begin
                    state_nxt = S_TAIL;
                end
            end
            S_TAIL: begin
                if (tail_end) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Run context, delay counter and table index.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            idx    <= '0;
            len_q  <= '0;
            mgmt_q <= '0;
`ifdef STREAM_TEST_DRIVER_REPEAT_EN
            rep_q    <= '0;
            pass_cnt <= '0;
`endif
        end else if (start_acc) begin
            cnt    <= '0;
            idx    <= '0;
            len_q  <= num_clamped;
            mgmt_q <= mgmt_value;
`ifdef STREAM_TEST_DRIVER_REPEAT_EN
            rep_q    <= repeat_count;
            pass_cnt <= '0;
`endif
        end else begin
            case (state)
                S_STARTUP: cnt <= startup_end ? '0 : cnt + CNT_W'(1);
                S_TAIL:    cnt <= cnt + CNT_W'(1);
                S_STREAM: begin
                    if (src_fire) begin
                        // Wrap at the end of every pass. The next pass then starts on the
                        // following cycle with sop set and no bubble.
                        if (last_beat) begin
                            idx <= '0;
`ifdef STREAM_TEST_DRIVER_REPEAT_EN
                            pass_cnt <= pass_cnt + 8'd1;
`endif
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from state. The table read is combinational, so data
    // follows idx in the same cycle and accepted beats can be back-to-back.
    // Data buses are forced to zero when not valid, so that reset clears every output.
    assign mgmt_valid        = (state == S_MGMT);
    assign mgmt_data         = mgmt_valid ? mgmt_q : '0;
    assign src_valid         = (state == S_STREAM);
    assign src_data          = src_valid ? tbl[idx] : '0;
    assign src_startofpacket = src_valid && (idx == '0);
    assign src_endofpacket   = src_valid && last_beat;
    assign busy              = !idle_like;
    assign done              = (state == S_DONE);

endmodule

// File: tb/tb_stream_test_driver.sv
// tb/tb_stream_test_driver.sv - scoreboard bench for stream_test_driver
module tb_stream_test_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  num_words = '0;
    logic [7:0]  mgmt_value = '0;
    logic        tbl_wr_en = 1'b0;
    logic [2:0]  tbl_wr_addr = '0;
    logic [15:0] tbl_wr_data = '0;
    logic        mgmt_valid;
    logic [7:0]  mgmt_data;
    logic        mgmt_ready = 1'b1;
    logic        src_valid;
    logic [15:0] src_data;
    logic        src_startofpacket;
    logic        src_endofpacket;
    logic        src_ready = 1'b1;
    logic        busy;
    logic        done;
`ifdef STREAM_TEST_DRIVER_REPEAT_EN
    logic [7:0]  repeat_count = '0;
    logic [7:0]  pass_cnt;
`endif

    stream_test_driver dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .num_words         (num_words),
        .mgmt_value        (mgmt_value),
`ifdef STREAM_TEST_DRIVER_REPEAT_EN
        .repeat_count      (repeat_count),
        .pass_cnt          (pass_cnt),
`endif
        .tbl_wr_en         (tbl_wr_en),
        .tbl_wr_addr       (tbl_wr_addr),
        .tbl_wr_data       (tbl_wr_data),
        .mgmt_valid        (mgmt_valid),
        .mgmt_data         (mgmt_data),
        .mgmt_ready        (mgmt_ready),
        .src_valid         (src_valid),
        .src_data          (src_data),
        .src_startofpacket (src_startofpacket),
        .src_endofpacket   (src_endofpacket),
        .src_ready         (src_ready),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [17:0] sq[$];
    logic [7:0]  mq[$];
    logic [15:0] tbl_model[8];
    int          last_acc_cyc = 0;
    int          mgmt_acc_cyc = 0;
    int          mstall = 0;
    int          sstall = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Ready generator. When enabled, it stalls the mgmt beat, and the stream beat
    // that carries b5de, for a fixed number of cycles.
    always @(posedge clk) begin
        #2;
        if (mstall > 0 && mgmt_valid) begin
            mgmt_ready = 1'b0;
            mstall--;
        end else begin
            mgmt_ready = 1'b1;
        end
        if (sstall > 0 && src_valid && src_data == 16'hb5de) begin
            src_ready = 1'b0;
            sstall--;
        end else begin
            src_ready = 1'b1;
        end
    end

    // Monitor. Any valid beat must match the head of its queue. The head is popped
    // only on a handshake, so a stalled beat is checked on every cycle it is held.
    always @(negedge clk) begin
        if (!reset) begin
            if (mgmt_valid) begin
                if (mq.size() == 0) check("mgmt_unexpected", 1, 0);
                else begin
                    check("mgmt_data", mgmt_data, mq[0]);
                    if (mgmt_ready) begin
                        mgmt_acc_cyc = cyc;
                        void'(mq.pop_front());
                    end
                end
            end
            if (src_valid) begin
                if (sq.size() == 0) check("beat_unexpected", 1, 0);
                else begin
                    check("beat", {src_data, src_startofpacket, src_endofpacket}, sq[0]);
                    if (src_ready) begin
                        if (src_endofpacket) last_acc_cyc = cyc;
                        void'(sq.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        tick();
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = a[2:0];
        tbl_wr_data = d;
        tick();
        tbl_wr_en   = 1'b0;
    endtask

    task automatic launch(input int n, input logic [7:0] mv, input int rep, output int s);
        int m;
        m = (n > 8) ? 8 : n;
        for (int p = 0; p <= rep; p++)
            for (int i = 0; i < m; i++)
                sq.push_back({tbl_model[i], (i == 0), (i == m - 1)});
        mq.push_back(mv);
        tick();
        start      = 1'b1;
        num_words  = 4'(n);
        mgmt_value = mv;
`ifdef STREAM_TEST_DRIVER_REPEAT_EN
        repeat_count = 8'(rep);
`endif
        s = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int s, input int exp_off);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 400);
        check(name, cyc - s, exp_off);
        check({name, "_queues"}, sq.size() + mq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s;
        tick();
        tick();
        @(negedge clk);
        check("reset_outputs", {mgmt_valid, src_valid, src_startofpacket, src_endofpacket,
                                busy, done, src_data, mgmt_data}, 0);
        tick();
        reset = 1'b0;

        tbl_model[0] = 16'h4949; tbl_model[1] = 16'hb5de; tbl_model[2] = 16'h9600;
        for (int i = 0; i < 3; i++) wr(i, tbl_model[i]);

        // Basic run: mgmt beat at +3, GAP, three beats, done 11 cycles after eop.
        launch(3, 8'h00, 0, s);
        wait_done("basic_done", s, 18);
        check("basic_mgmt_latency", mgmt_acc_cyc - s, 3);
        check("basic_tail", cyc - last_acc_cyc, 11);

        // Backpressure: 2 mgmt stall cycles and 4 on b5de, so done is 6 cycles later.
        mstall = 2;
        sstall = 4;
        launch(3, 8'ha5, 0, s);
        wait_done("bp_done", s, 24);
        check("bp_mgmt_latency", mgmt_acc_cyc - s, 5);
        check("bp_stalls_used", mstall + sstall, 0);
        check("bp_tail", cyc - last_acc_cyc, 11);

        // A table write and a start during STREAM must both be ignored.
        launch(3, 8'h3c, 0, s);
        while (cyc < s + 5) tick();
        check("stream_busy", busy, 1);
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = 3'd0;
        tbl_wr_data = 16'h1234;
        tick();
        tbl_wr_en = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ignored_done", s, 18);

        // Reset in the cycle after the second beat is accepted.
        launch(3, 8'h11, 0, s);
        while (cyc < s + 7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        sq.delete();
        check("reset_mid_outputs", {mgmt_valid, src_valid, src_startofpacket, src_endofpacket,
                                    busy, done, src_data, mgmt_data}, 0);
        check("reset_mid_mgmt_q", mq.size(), 0);

        // num_words=0: mgmt beat only. num_words=1: single beat with sop and eop both set.
        launch(0, 8'h77, 0, s);
        wait_done("nw0_done", s, 15);
        launch(1, 8'h01, 0, s);
        wait_done("nw1_done", s, 16);

        // num_words=15 is clamped to DEPTH=8 beats.
        for (int i = 0; i < 8; i++) begin
            tbl_model[i] = 16'h1000 + 16'(i);
            wr(i, tbl_model[i]);
        end
        launch(15, 8'hc3, 0, s);
        wait_done("nw15_done", s, 23);
        repeat (5) tick();
        @(negedge clk);
        check("done_held", {done, busy}, 2'b10);

`ifdef STREAM_TEST_DRIVER_REPEAT_EN
        tbl_model[0] = 16'h4949; tbl_model[1] = 16'hb5de; tbl_model[2] = 16'h9600;
        for (int i = 0; i < 3; i++) wr(i, tbl_model[i]);
        launch(3, 8'h5a, 2, s);
        wait_done("repeat_done", s, 24);
        check("repeat_pass_cnt", pass_cnt, 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stream_test_driver.md
Name: stream_test_driver

Overview:
- Synthesizable, parametrised traffic generator for on-chip bring-up of the hash core.
- Sequence per run: wait out a startup delay, issue one management beat, then replay a loadable word table on the core's Avalon-ST input with full ready/valid backpressure and packet framing.
- Generalises the fixed three-word, 16-bit simulation stimulus to configurable width, depth and length. Adds a done indication.
- Sits between a host/debug register block and the core's mgmt and in sinks.

Parameters:
- DATA_W, 16, width of stream data words.
- DEPTH, 8, number of entries in the word table (power of two, >=2).
- MGMT_W, 8, width of the management data beat.
- STARTUP_DELAY, 2, idle cycles between accepted start and the mgmt beat (>=1).
- TAIL_DELAY, 10, cycles after the last accepted stream beat before done asserts (>=1).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle run request.
- num_words  in  $clog2(DEPTH+1)  words to send; sampled on accepted start; values >DEPTH clamp to DEPTH.
- mgmt_value  in  MGMT_W  mgmt payload; sampled on accepted start.
- tbl_wr_en  in  1  table write strobe.
- tbl_wr_addr  in  $clog2(DEPTH)  table write address.
- tbl_wr_data  in  DATA_W  table write data.
- mgmt_valid  out  1  Avalon-ST mgmt source valid.
- mgmt_data  out  MGMT_W  mgmt source data.
- mgmt_ready  in  1  mgmt sink ready.
- src_valid  out  1  stream source valid.
- src_data  out  DATA_W  stream data.
- src_startofpacket  out  1  first beat of run.
- src_endofpacket  out  1  last beat of run.
- src_ready  in  1  stream sink ready.
- busy  out  1  high in any state except IDLE/DONE.
- done  out  1  high in DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset).
- Reset values: all outputs 0; state IDLE; counters 0. Table contents are not reset.
- Reset mid-operation: state returns to IDLE at the next edge; valids drop without completing the handshake.
- Table writes: accepted only in IDLE or DONE; ignored while busy.
- States: IDLE, STARTUP, MGMT, GAP, STREAM, TAIL, DONE.
- IDLE/DONE, start=1 -> STARTUP:
  - Latch clamped num_words and mgmt_value.
  - Clear done.
  - start while busy is ignored.
- STARTUP: count STARTUP_DELAY cycles, then -> MGMT.
  - Start accepted at edge t gives mgmt_valid=1 in the cycle after edge t+STARTUP_DELAY.
- MGMT:
  - mgmt_valid=1, mgmt_data=latched value, held stable until mgmt_ready.
  - On valid&&ready -> GAP; mgmt_valid=0 in the next cycle.
- GAP: exactly one cycle.
  - Then -> STREAM if length>0.
  - Else -> TAIL; no stream beats and no sop/eop are emitted.
- STREAM:
  - src_valid=1, src_data=table[idx], idx starts at 0.
  - src_startofpacket=1 when idx==0; src_endofpacket=1 when idx==length-1. Both are set on the same beat when length==1.
  - While valid&&!ready, data and sop/eop are held stable.
  - On valid&&ready: idx++. Beats are back-to-back when ready stays high.
  - After the last beat is accepted -> TAIL; src_valid=0 in the next cycle.
- TAIL: count TAIL_DELAY cycles -> DONE.
- DONE: done=1, held until the next accepted start or reset.
- Table read is a registered or combinational index into the table; no bubble is allowed between accepted beats.

Optional Feature:
- Macro: STREAM_TEST_DRIVER_REPEAT_EN.
- With the macro:
  - Extra input repeat_count [7:0], sampled on start.
  - The table is replayed repeat_count+1 times, with one packet per pass (sop/eop per pass) and no gap between passes.
  - Extra output pass_cnt [7:0] counts completed passes; reset on start.
  - TAIL is entered after the final pass.
- Without the macro: single pass; those ports do not exist.

Test Plan:
- Basic run:
  - Stimulus: table={4949,b5de,9600}, num_words=3, mgmt_value=8'h00, ready high.
  - Response: mgmt beat 3 cycles after start; one GAP cycle; src_data 4949/b5de/9600 on consecutive cycles, sop on 4949, eop on 9600; done exactly 11 cycles after the 9600 beat is accepted.
- Backpressure:
  - Stimulus: same run, src_ready low for 4 cycles on the b5de beat and mgmt_ready low for 2 cycles.
  - Response: data and sop/eop stable while stalled; beat order unchanged; done delayed by exactly the stall count.
- Boundaries:
  - num_words=0 -> mgmt beat only, no src_valid, done after TAIL.
  - num_words=1 -> single beat with sop=eop=1.
  - num_words=15 with DEPTH=8 -> exactly 8 beats.
- Reset and ignored writes/starts:
  - reset asserted in the cycle after the second beat is accepted -> all outputs 0 at the next edge.
  - A table write during STREAM (addr 0, data 1234) is ignored; a subsequent run still sends 4949 first.
  - start pulsed during STREAM is ignored.
- Repeat feature (macro defined):
  - Stimulus: repeat_count=2, num_words=3.
  - Response: 9 beats, sop at beats 1/4/7, eop at 3/6/9, pass_cnt ends at 3, done after TAIL.
